// File: rtl/dac_spi_out_if.sv
// DAC serial link bundle.
// Carries the three wires between the waveform serializer and the external DAC.
//   dac_cs_n : chip select, active low
//   dac_sclk : serial clock, DAC samples dac_din on its rising edge
//   dac_din  : serial data, MSB first
// Modports: master (serializer drives), slave (DAC side observes).
interface dac_spi_out_if;
    logic dac_cs_n;
    logic dac_sclk;
    logic dac_din;

    modport master (output dac_cs_n, output dac_sclk, output dac_din);
    modport slave  (input  dac_cs_n, input  dac_sclk, input  dac_din);
endinterface

// File: rtl/dac_spi_out.sv
// Periodic waveform-sample serializer for a 16-bit SPI DAC.
// Every SMP_DIV clocks a sample is taken from the waveform selected by sel and
// shifted out as {4'b0000, code[7:0], 4'b0000}, MSB first.
// Optional feature: define DAC_AMP_SCALE_EN to attenuate the sample by a logical
// right shift of amp bits; without it amp is accepted but ignored.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   num_juchi/sanjiao/sin/fangbo : 8-bit sawtooth/triangle/sine/square samples
//   sel               : waveform select 0..3
//   amp               : attenuation shift 0..3
//   dac               : SPI link (cs_n, sclk, din), master side
//   busy              : high while a frame or its cs_n recovery is in progress
//   ovf               : one-cycle pulse when a sample tick arrives while busy
// All outputs come straight from flops.
module dac_spi_out #(
    parameter int unsigned SMP_DIV = 200,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_HIGH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    num_juchi,
    input  logic [7:0]    num_sanjiao,
    input  logic [7:0]    num_sin,
    input  logic [7:0]    num_fangbo,
    input  logic [1:0]    sel,
    input  logic [1:0]    amp,
    dac_spi_out_if.master dac,
    output logic          busy,
    output logic          ovf
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] smp_cnt_q, smp_cnt_d;
    logic [7:0]  code_q, code_d;
    // Shared timer: sclk half-period divider in SHIFT, cs_n high time in HOLD.
    logic [7:0]  cnt_q, cnt_d;
    // Index of the current sclk half-period within the 32-half frame.
    logic [4:0]  half_q, half_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        tick;
    logic [7:0]  sample;
    logic [7:0]  captured;
    logic [15:0] frame_d;

    assign tick      = (smp_cnt_q == 16'(SMP_DIV - 1));
    assign smp_cnt_d = tick ? 16'd0 : smp_cnt_q + 16'd1;

    always_comb begin
        sample = num_juchi;
        unique case (sel)
            2'd0: sample = num_juchi;
            2'd1: sample = num_sanjiao;
            2'd2: sample = num_sin;
            2'd3: sample = num_fangbo;
            default: sample = num_juchi;
        endcase
    end

`ifdef DAC_AMP_SCALE_EN
    assign captured = sample >> amp;
`else
    logic unused_amp;
    assign unused_amp = ^amp;
    assign captured   = sample;
`endif

    // State and timer update.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StLoad;
                    code_d  = captured;
                end
            end
            StLoad: begin
                state_d = StShift;
                cnt_d   = 8'd0;
                half_d  = 5'd0;
            end
            StShift: begin
                if (cnt_q == 8'(CLK_DIV - 1)) begin
                    cnt_d  = 8'd0;
                    half_d = half_q + 5'd1;
                    if (half_q == 5'd31) begin
                        state_d = StHold;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == 8'(CS_HIGH - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    assign frame_d = {4'b0000, code_d, 4'b0000};

    always_comb begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        din_d  = 1'b0;
        busy_d = (state_d != StIdle);
        ovf_d  = tick && (state_q != StIdle);
        if (state_d == StLoad) begin
            cs_n_d = 1'b0;
            din_d  = frame_d[15];
        end else if (state_d == StShift) begin
            cs_n_d = 1'b0;
            // Odd halves are sclk high; the bit index only moves on even
            // halves, so din changes together with the falling edge.
            sclk_d = half_d[0];
            din_d  = frame_d[4'd15 - half_d[4:1]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            smp_cnt_q <= 16'd0;
            code_q    <= 8'd0;
            cnt_q     <= 8'd0;
            half_q    <= 5'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign dac.dac_cs_n = cs_n_q;
    assign dac.dac_sclk = sclk_q;
    assign dac.dac_din  = din_q;
    assign busy         = busy_q;
    assign ovf          = ovf_q;

endmodule

// File: doc/dac_spi_out.md
DAC_SPI_OUT -- requirements
Module: dac_spi_out

Interface
REQ-001 The block SHALL have parameter SMP_DIV, default 200, giving the sample period in clk cycles (legal range 2..65535).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk cycles (legal range 1..255).
REQ-003 The block SHALL have parameter CS_HIGH, default 8, giving the minimum cs_n high time in clk cycles after each frame (legal range 1..255).
REQ-004 clk  input  1  system clock; every register SHALL use the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have inputs num_juchi, num_sanjiao, num_sin and num_fangbo, each input 8 bits, carrying the sawtooth, triangle, sine and square ROM data.
REQ-007 sel  input  2  waveform select: 0 juchi, 1 sanjiao, 2 sin, 3 fangbo.
REQ-008 amp  input  2  attenuation shift, 0..3.
REQ-009 dac_cs_n  output  1  DAC chip select, active low.
REQ-010 dac_sclk  output  1  DAC serial clock.
REQ-011 dac_din  output  1  DAC serial data, MSB first.
REQ-012 busy  output  1  high while the state is not IDLE.
REQ-013 ovf  output  1  one-cycle pulse when a sample tick is dropped.

Function
REQ-014 A free-running counter SHALL count 0..SMP_DIV-1 and wrap; a tick occurs on the cycle count==SMP_DIV-1.
REQ-015 The FSM SHALL have four states: IDLE, LOAD, SHIFT and HOLD.
REQ-016 On a tick in IDLE, the FSM SHALL go to LOAD on the next edge and SHALL latch the sel-selected waveform into code[7:0] on that same edge.
REQ-017 A tick in any state other than IDLE SHALL be dropped and SHALL pulse ovf for exactly one cycle.
REQ-018 A change of sel or amp during a frame SHALL NOT affect that frame; the new value takes effect at the next capture.
REQ-019 The frame SHALL be 16 bits, {4'b0000, code[7:0], 4'b0000}, sent MSB first.
REQ-020 In LOAD (one cycle), cs_n SHALL be 0, sclk SHALL be 0, din SHALL be frame bit 15, and the next state SHALL be SHIFT.
REQ-021 In SHIFT, sclk SHALL toggle every CLK_DIV cycles, starting low, producing 16 rising edges.
REQ-022 In SHIFT, din SHALL change only on sclk falling edges, so the DAC samples din on rising edges.
REQ-023 SHIFT SHALL last exactly 32*CLK_DIV cycles and then transition to HOLD, with sclk low.
REQ-024 In HOLD, cs_n SHALL be 1 and sclk SHALL be 0 for CS_HIGH cycles, then the FSM SHALL transition to IDLE.
REQ-025 Frame occupancy SHALL be 1 + 32*CLK_DIV + CS_HIGH cycles; with the defaults this is 137 cycles, below SMP_DIV, so ovf never fires.
REQ-026 In IDLE, cs_n SHALL be 1, sclk SHALL be 0 and din SHALL be 0.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 While rst_n=0, the block SHALL hold the FSM in IDLE, the sample counter at 0, code at 0, dac_cs_n at 1, dac_sclk at 0, dac_din at 0, busy at 0 and ovf at 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with cs_n high asynchronously.
REQ-030 After rst_n deasserts, the first tick SHALL occur SMP_DIV cycles later.

Configuration
REQ-031 When macro DAC_AMP_SCALE_EN is defined, code SHALL equal the selected sample logically right-shifted by amp; for example, 0xF0 with amp=2 gives 0x3C.
REQ-032 When DAC_AMP_SCALE_EN is undefined, the amp port SHALL remain present but be ignored, and code SHALL equal the selected sample.

Verification
REQ-033 Scenario 1: defaults, sel=2, num_sin=0xA5 -> cs_n low 1 cycle after the tick; 16 bits 0x0A50 sampled on sclk rises; cs_n high after 129 cycles; busy high 137 cycles.
REQ-034 Scenario 2: sel swept 0..3 with inputs 0x11/0x22/0x33/0x44 over four samples -> frames 0x0110, 0x0220, 0x0330, 0x0440.
REQ-035 Scenario 3: SMP_DIV=100 with default CLK_DIV and CS_HIGH -> ovf pulses once per dropped tick; every other frame is lost; no frame is truncated.
REQ-036 Scenario 4: rst_n pulsed low at SHIFT bit 7 -> cs_n=1, sclk=0 in the same cycle; the next frame is complete and correct.
REQ-037 Scenario 5: sel changed from 0 to 3 during SHIFT -> the current frame keeps the juchi value; the next frame carries the fangbo value.
REQ-038 Scenario 6: with DAC_AMP_SCALE_EN defined, amp=3 and sample 0xFF -> frame 0x01F0; with the macro undefined -> frame 0x0FF0.
